// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory read at a time, feeds each returned
// word to the combinational branch predictor and queues {pc, word, prediction} for decode.
// Redirects from EX/MEM flush the queue and drop any in-flight read.
// Optional: define FETCH_PERF_CNT_EN to add saturating push / flush performance counters.
`timescale 1ns/1ps

module fetch_pc_unit #(
  parameter int unsigned              ADDRESS_BITS = 20,
  parameter int unsigned              DATA_WIDTH   = 32,
  parameter logic [ADDRESS_BITS-1:0]  RESET_PC     = '0,
  parameter int unsigned              FQ_DEPTH     = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [ADDRESS_BITS-1:0] imem_req_addr,
  input  logic                    imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   imem_rsp_data,
  output logic [ADDRESS_BITS-1:0] bp_inst_PC,
  output logic [DATA_WIDTH-1:0]   bp_instruction,
  input  logic                    bp_predict_taken,
  input  logic [ADDRESS_BITS-1:0] bp_predicted_addr,
  input  logic                    exmem_redirect,
  input  logic [ADDRESS_BITS-1:0] exmem_redirect_pc,
  output logic                    fq_valid,
  input  logic                    fq_ready,
  output logic [ADDRESS_BITS-1:0] fq_inst_PC,
  output logic [DATA_WIDTH-1:0]   fq_instruction,
  output logic                    fq_pred_taken,
  output logic [ADDRESS_BITS-1:0] fq_pred_target
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]             perf_fetched,
  output logic [31:0]             perf_flushed
`endif
);

  localparam int unsigned PtrW = $clog2(FQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIssue, StWait, StDiscard} state_e;

  typedef struct packed {
    logic [ADDRESS_BITS-1:0] pc;
    logic [DATA_WIDTH-1:0]   word;
    logic                    taken;
    logic [ADDRESS_BITS-1:0] target;
  } fq_entry_t;

  state_e                  state_q;
  logic [ADDRESS_BITS-1:0] pc_q;
  fq_entry_t               fq_mem [FQ_DEPTH];
  logic [PtrW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]         count_q;

  logic                    push, pop, req_fire;
  logic [CntW-1:0]         count_after_pop;
  logic [ADDRESS_BITS-1:0] next_pc;
  fq_entry_t               head;

  // Handshake decode; redirect suppresses push, pop and any new request in the same cycle.
  always_comb begin
    fq_valid        = !reset && (count_q != '0);
    pop             = fq_valid && fq_ready && !exmem_redirect;
    push            = imem_rsp_valid && (state_q == StWait) && !exmem_redirect;
    count_after_pop = count_q - CntW'(pop);
    // Issuing only with a free slot guarantees room for the response when it returns.
    imem_req_valid  = !reset && !exmem_redirect && (state_q == StIssue) &&
                      (count_after_pop < CntW'(FQ_DEPTH));
    req_fire        = imem_req_valid && imem_req_ready;
    next_pc         = bp_predict_taken ? bp_predicted_addr : pc_q + ADDRESS_BITS'(4);
    imem_req_addr   = pc_q;
    bp_inst_PC      = pc_q;
    bp_instruction  = imem_rsp_data;
    head            = fq_mem[rd_ptr_q];
    fq_inst_PC      = head.pc;
    fq_instruction  = head.word;
    fq_pred_taken   = head.taken;
    fq_pred_target  = head.target;
  end

  // Fetch FSM and PC; redirect wins over everything except reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIssue;
      pc_q    <= RESET_PC;
    end else if (exmem_redirect) begin
      pc_q    <= exmem_redirect_pc;
      // A read still in flight must be swallowed before fetching restarts.
      state_q <= (state_q != StIssue && !imem_rsp_valid) ? StDiscard : StIssue;
    end else begin
      case (state_q)
        StIssue: begin
          if (req_fire) state_q <= StWait;
        end
        StWait: begin
          if (imem_rsp_valid) begin
            state_q <= StIssue;
            pc_q    <= next_pc;
          end
        end
        StDiscard: begin
          if (imem_rsp_valid) state_q <= StIssue;
        end
        default: state_q <= StIssue;
      endcase
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clock) begin
    if (reset || exmem_redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Queue storage; entries are only meaningful while counted, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push) begin
      fq_mem[wr_ptr_q] <= '{pc: pc_q, word: imem_rsp_data, taken: bp_predict_taken,
                            target: next_pc};
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        dropped;
  logic [32:0] flushed_sum;

  // Flushed work this cycle: queued entries lost to a redirect plus any response thrown away.
  always_comb begin
    dropped     = imem_rsp_valid &&
                  ((state_q == StDiscard) || (state_q == StWait && exmem_redirect));
    flushed_sum = {1'b0, perf_flushed} + 33'(dropped);
    if (exmem_redirect) flushed_sum = flushed_sum + 33'(count_q);
  end

  // Saturating performance counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push && perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 32'd1;
      perf_flushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: a 1..N cycle memory model, a table-driven fetch/prediction sequence
// and hand-written redirect, back-pressure and reset corner cases, checked by a scoreboard.
`timescale 1ns/1ps

module tb_fetch_pc_unit;

  localparam int AW    = 20;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam logic [AW-1:0] RST_PC  = '0;
  localparam logic [AW-1:0] NO_PRED = 20'hFFFFF;  // odd, never fetched

  logic          clock = 1'b0;
  logic          reset;
  logic          imem_req_valid, imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic [AW-1:0] bp_inst_PC;
  logic [DW-1:0] bp_instruction;
  logic          bp_predict_taken;
  logic [AW-1:0] bp_predicted_addr;
  logic          exmem_redirect;
  logic [AW-1:0] exmem_redirect_pc;
  logic          fq_valid, fq_ready;
  logic [AW-1:0] fq_inst_PC;
  logic [DW-1:0] fq_instruction;
  logic          fq_pred_taken;
  logic [AW-1:0] fq_pred_target;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_fetched, perf_flushed;
`endif

  always #5 clock = ~clock;

  fetch_pc_unit #(
    .ADDRESS_BITS(AW),
    .DATA_WIDTH  (DW),
    .RESET_PC    (RST_PC),
    .FQ_DEPTH    (DEPTH)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .bp_inst_PC       (bp_inst_PC),
    .bp_instruction   (bp_instruction),
    .bp_predict_taken (bp_predict_taken),
    .bp_predicted_addr(bp_predicted_addr),
    .exmem_redirect   (exmem_redirect),
    .exmem_redirect_pc(exmem_redirect_pc),
    .fq_valid         (fq_valid),
    .fq_ready         (fq_ready),
    .fq_inst_PC       (fq_inst_PC),
    .fq_instruction   (fq_instruction),
    .fq_pred_taken    (fq_pred_taken),
    .fq_pred_target   (fq_pred_target)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched     (perf_fetched),
    .perf_flushed     (perf_flushed)
`endif
  );

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] word;
    logic          taken;
    logic [AW-1:0] target;
  } fq_exp_t;

  typedef struct {
    logic          redir_before;
    logic [AW-1:0] addr;
    logic          taken;
    logic [AW-1:0] target;
  } vec_t;

  fq_exp_t exp_q[$];
  vec_t    tbl[12];

  int checks, failures;
  int acc_cnt, mem_cnt, mem_lat, exp_fetched, exp_flushed;
  logic          mem_busy, mem_drop, redir, stray, fq_rdy, req_rdy;
  logic [AW-1:0] mem_addr, exp_pc, pt_addr, pt_target, redir_pc, last_acc;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {12'hA5C, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One clock cycle: memory model + predictor drive, scoreboard update, output checks.
  task automatic cycle();
    int      pre_size;
    logic    busy_start, rsp, pop_exp, exp_req;
    fq_exp_t e;
    pre_size   = exp_q.size();
    busy_start = mem_busy;
    rsp        = mem_busy && (mem_cnt == 0);
    imem_rsp_valid    = rsp || stray;
    imem_rsp_data     = rsp ? word_of(mem_addr) : 32'hDEAD_BEEF;
    bp_predict_taken  = rsp && (mem_addr == pt_addr);
    bp_predicted_addr = bp_predict_taken ? pt_target : mem_addr + AW'(4);
    exmem_redirect    = redir;
    exmem_redirect_pc = redir_pc;
    fq_ready          = fq_rdy;
    imem_req_ready    = req_rdy;
    if (redir) begin
      exp_flushed += pre_size + (rsp ? 1 : 0);
      exp_q.delete();
      exp_pc = redir_pc;
      if (mem_busy && !rsp) mem_drop = 1'b1;
    end else if (rsp) begin
      if (mem_drop) begin
        exp_flushed++;
      end else begin
        e.pc = mem_addr; e.word = word_of(mem_addr);
        e.taken = bp_predict_taken; e.target = bp_predicted_addr;
        exp_q.push_back(e);
        exp_pc = bp_predicted_addr;
        exp_fetched++;
      end
    end
    #2;
    if (rsp && !mem_drop && !redir) chk("bp_inst_PC", 64'(bp_inst_PC), 64'(mem_addr));
    if (rsp) begin
      mem_busy = 1'b0;
      mem_drop = 1'b0;
    end else if (mem_busy) begin
      mem_cnt--;
    end
    pop_exp = !redir && (pre_size != 0) && fq_rdy;
    exp_req = !busy_start && !redir && ((pre_size - (pop_exp ? 1 : 0)) < DEPTH);
    chk("fq_valid", 64'(fq_valid), 64'(pre_size != 0));
    chk("req_valid", 64'(imem_req_valid), 64'(exp_req));
    if (imem_req_valid) chk("req_addr", 64'(imem_req_addr), 64'(exp_pc));
    if (pop_exp && fq_valid) begin
      e = exp_q.pop_front();
      chk("fq_inst_PC", 64'(fq_inst_PC), 64'(e.pc));
      chk("fq_instruction", 64'(fq_instruction), 64'(e.word));
      chk("fq_pred_taken", 64'(fq_pred_taken), 64'(e.taken));
      chk("fq_pred_target", 64'(fq_pred_target), 64'(e.target));
    end
    if (imem_req_valid && req_rdy) begin
      acc_cnt++;
      last_acc = imem_req_addr;
      mem_busy = 1'b1;
      mem_drop = 1'b0;
      mem_addr = exp_pc;
      mem_cnt  = mem_lat - 1;
    end
    @(posedge clock);
    #1;
    redir = 1'b0;
    stray = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redir = 1'b0; stray = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; bp_predict_taken = 1'b0;
    bp_predicted_addr = '0; exmem_redirect = 1'b0; exmem_redirect_pc = '0;
    fq_ready = fq_rdy; imem_req_ready = req_rdy;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
      chk("rst_fq_valid", 64'(fq_valid), 64'(0));
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    exp_q.delete();
    mem_busy = 1'b0; mem_drop = 1'b0;
    exp_pc = RST_PC; exp_fetched = 0; exp_flushed = 0;
  endtask

  task automatic wait_accept(input string name, input logic [AW-1:0] a);
    int start;
    start = acc_cnt;
    for (int i = 0; i < 30; i++) begin
      if (acc_cnt != start) break;
      cycle();
    end
    chk({name, "_seen"}, 64'(acc_cnt != start), 64'(1));
    chk(name, 64'(last_acc), 64'(a));
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 30; i++) begin
      if (!mem_busy) break;
      cycle();
    end
    chk("rsp_timeout", 64'(mem_busy), 64'(0));
  endtask

  task automatic drain();
    req_rdy = 1'b0;
    fq_rdy  = 1'b1;
    wait_rsp();
    for (int i = 0; i < DEPTH + 1; i++) cycle();
  endtask

  task automatic check_perf();
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", 64'(perf_fetched), 64'(exp_fetched));
    chk("perf_flushed", 64'(perf_flushed), 64'(exp_flushed));
`endif
  endtask

  initial begin
    int start;
    // {redirect first, expected request address, predict taken, predicted target}
    tbl[0]  = '{1'b0, 20'h00000, 1'b0, 20'h00000};
    tbl[1]  = '{1'b0, 20'h00004, 1'b0, 20'h00000};
    tbl[2]  = '{1'b0, 20'h00008, 1'b0, 20'h00000};
    tbl[3]  = '{1'b0, 20'h0000C, 1'b0, 20'h00000};
    tbl[4]  = '{1'b0, 20'h00010, 1'b1, 20'h00040};
    tbl[5]  = '{1'b0, 20'h00040, 1'b0, 20'h00000};
    tbl[6]  = '{1'b0, 20'h00044, 1'b1, 20'h00010};
    tbl[7]  = '{1'b0, 20'h00010, 1'b0, 20'h00000};
    tbl[8]  = '{1'b1, 20'hFFFF8, 1'b0, 20'h00000};
    tbl[9]  = '{1'b0, 20'hFFFFC, 1'b0, 20'h00000};
    tbl[10] = '{1'b0, 20'h00000, 1'b0, 20'h00000};
    tbl[11] = '{1'b0, 20'h00004, 1'b0, 20'h00000};

    checks = 0; failures = 0; acc_cnt = 0; mem_cnt = 0; mem_lat = 1;
    pt_addr = NO_PRED; pt_target = '0; redir_pc = '0; last_acc = '0; mem_addr = '0;
    fq_rdy = 1'b1; req_rdy = 1'b1;
    do_reset();

    // Sequential fetch, taken branches and PC wrap-around.
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].redir_before) begin
        redir    = 1'b1;
        redir_pc = tbl[i].addr;
        cycle();
      end
      pt_addr   = tbl[i].taken ? tbl[i].addr : NO_PRED;
      pt_target = tbl[i].target;
      wait_accept("tbl_req_addr", tbl[i].addr);
      wait_rsp();
    end
    pt_addr = NO_PRED;

    // Decode stalled: exactly DEPTH reads, then fetch stops until decode drains.
    drain();
    fq_rdy = 1'b0; req_rdy = 1'b1;
    start = acc_cnt;
    for (int i = 0; i < 12; i++) cycle();
    chk("full_accepts", 64'(acc_cnt - start), 64'(DEPTH));
    chk("full_fq_valid", 64'(fq_valid), 64'(1));
    chk("full_req_valid", 64'(imem_req_valid), 64'(0));
    fq_rdy = 1'b1;
    wait_accept("resume_req", 20'h00010);
    wait_rsp();

    // Redirect while waiting: late response dropped, queue flushed, restart at target.
    drain();
    fq_rdy = 1'b0; req_rdy = 1'b1; mem_lat = 1;
    wait_accept("t4_a", 20'h00014);
    wait_rsp();
    mem_lat = 3;
    wait_accept("t4_b", 20'h00018);
    redir = 1'b1; redir_pc = 20'h00100;
    cycle();
    chk("t4_flushed", 64'(fq_valid), 64'(0));
    mem_lat = 1; fq_rdy = 1'b1;
    wait_accept("t4_redir_req", 20'h00100);
    wait_rsp();

    // Redirect coincident with a response and a decode pop.
    drain();
    fq_rdy = 1'b0; req_rdy = 1'b1; mem_lat = 1;
    wait_accept("t5_a", 20'h00104);
    wait_rsp();
    mem_lat = 2;
    wait_accept("t5_b", 20'h00108);
    for (int i = 0; i < 10; i++) begin
      if (mem_busy && mem_cnt == 0) break;
      cycle();
    end
    redir = 1'b1; redir_pc = 20'h00200; fq_rdy = 1'b1;
    cycle();
    chk("t5_fq_empty", 64'(fq_valid), 64'(0));
    mem_lat = 1;
    wait_accept("t5_redir_req", 20'h00200);
    wait_rsp();
    check_perf();

    // Reset with a read in flight; its late response must be ignored.
    mem_lat = 3;
    wait_accept("t7_a", 20'h00204);
    do_reset();
    req_rdy = 1'b0; stray = 1'b1;
    cycle();
    cycle();
    chk("t7_no_push", 64'(fq_valid), 64'(0));
    req_rdy = 1'b1; mem_lat = 1;
    wait_accept("t7_after_reset", RST_PC);
    wait_rsp();
    cycle();
    check_perf();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
